// File: rtl/credit_arbiter_pkg.sv
// Shared constants and types for the credit-based round-robin arbiter.
package credit_arbiter_pkg;

    localparam int unsigned NREQ_MAX = 8;
    localparam int unsigned STAT_W   = 16;
    localparam int unsigned IDX_W    = $clog2(NREQ_MAX);

    typedef logic [IDX_W-1:0] req_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot selector: searches from ptr+1 (mod NREQ) for the first eligible requester.
module rr_arbiter
    import credit_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0] eligible,
    input  req_idx_t        ptr,
    output logic [NREQ-1:0] grant
);

    logic [IDX_W:0]    shamt;
    logic [2*NREQ-1:0] elig_dbl;
    logic [2*NREQ-1:0] gnt_dbl;
    logic [NREQ-1:0]   rot;
    logic [NREQ-1:0]   rot_gnt;

    // Rotate so the search start sits at bit 0, pick the lowest set bit, rotate back.
    always_comb begin
        shamt    = {1'b0, ptr} + (IDX_W + 1)'(1);
        elig_dbl = {eligible, eligible} >> shamt;
        rot      = elig_dbl[NREQ-1:0];
        rot_gnt  = rot & (~rot + NREQ'(1));
        gnt_dbl  = {rot_gnt, rot_gnt} << shamt;
        grant    = gnt_dbl[2*NREQ-1:NREQ];
    end

endmodule

// File: rtl/credit_arbiter.sv
// Credit-gated round-robin arbiter feeding a shared downstream FIFO.
// Optional per-requester grant statistics are enabled with CREDIT_ARBITER_STATS_EN.
module credit_arbiter
    import credit_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned CREDITS = DEPTH / NREQ,
    localparam int unsigned IDW    = $clog2(NREQ),
    localparam int unsigned CW     = $clog2(CREDITS) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      fifo_data,
    output logic [IDW-1:0]        fifo_id,
    output logic                  fifo_we,
    input  logic                  credit_ret,
    input  logic [IDW-1:0]        credit_id,
    output logic                  credit_err,
    output logic [NREQ*CW-1:0]    credit_cnt
`ifdef CREDIT_ARBITER_STATS_EN
    ,
    input  logic [IDW-1:0]        stat_sel,
    input  logic                  stat_clr,
    output logic [STAT_W-1:0]     stat_cnt
`endif
);

    // Total credits must fit the FIFO so it can never be written while full.
    if (CREDITS * NREQ > DEPTH) begin : g_bad_credits
        $error("credit_arbiter: CREDITS*NREQ exceeds DEPTH");
    end
    if (NREQ < 2 || NREQ > NREQ_MAX) begin : g_bad_nreq
        $error("credit_arbiter: NREQ out of range");
    end

    logic [CW-1:0]    credit_q [NREQ];
    logic [CW-1:0]    credit_d [NREQ];
    logic [NREQ-1:0]  eligible;
    logic [NREQ-1:0]  grant;
    logic [NREQ-1:0]  accept_vec;
    logic [NREQ-1:0]  inc_vec;
    logic             accept;
    logic             id_ok;
    logic             err_d;
    req_idx_t         ptr_q;
    req_idx_t         gnt_idx;
    logic [WIDTH-1:0] sel_data;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = req_valid[i] && (credit_q[i] != '0);
        end
    end

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .eligible (eligible),
        .ptr      (ptr_q),
        .grant    (grant)
    );

    // No grant may be visible while reset is held.
    assign req_ready  = grant & {NREQ{reset_n}};
    assign accept_vec = req_valid & req_ready;
    assign accept     = |accept_vec;

    always_comb begin
        gnt_idx  = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gnt_idx = req_idx_t'(i);
            end
            sel_data = sel_data | ({WIDTH{grant[i]}} & req_data[i*WIDTH +: WIDTH]);
        end
    end

    assign id_ok = (32'(credit_id) < NREQ);

    always_comb begin
        err_d   = credit_err;
        inc_vec = '0;
        if (credit_ret && !id_ok) begin
            err_d = 1'b1;
        end
        for (int i = 0; i < NREQ; i++) begin
            inc_vec[i]  = credit_ret && id_ok && (credit_id == IDW'(i));
            credit_d[i] = credit_q[i];
            if (inc_vec[i] && !accept_vec[i]) begin
                if (credit_q[i] == CW'(CREDITS)) begin
                    err_d = 1'b1;
                end else begin
                    credit_d[i] = credit_q[i] + CW'(1);
                end
            end else if (accept_vec[i] && !inc_vec[i]) begin
                credit_d[i] = credit_q[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q      <= req_idx_t'(NREQ - 1);
            fifo_we    <= 1'b0;
            fifo_data  <= '0;
            fifo_id    <= '0;
            credit_err <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                credit_q[i] <= CW'(CREDITS);
            end
        end else begin
            fifo_we    <= accept;
            credit_err <= err_d;
            if (accept) begin
                ptr_q     <= gnt_idx;
                fifo_data <= sel_data;
                fifo_id   <= gnt_idx[IDW-1:0];
            end
            for (int i = 0; i < NREQ; i++) begin
                credit_q[i] <= credit_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            credit_cnt[i*CW +: CW] = credit_q[i];
        end
    end

`ifdef CREDIT_ARBITER_STATS_EN
    logic [STAT_W-1:0] stat_q [NREQ];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREQ; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (stat_clr) begin
                    stat_q[i] <= '0;
                end else if (accept_vec[i] && (stat_q[i] != '1)) begin
                    stat_q[i] <= stat_q[i] + STAT_W'(1);
                end
            end
        end
    end

    assign stat_cnt = (32'(stat_sel) < NREQ) ? stat_q[stat_sel] : '0;
`endif

endmodule

// File: doc/credit_arbiter.md
CREDIT_ARBITER -- requirements
Module: credit_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, data width; NREQ, default 4, requester count (2..8); DEPTH, default 32, downstream FIFO depth; CREDITS, default DEPTH/NREQ, initial credits per requester.
REQ-002 clk  input  1  the one clock; all logic on its rising edge.
REQ-003 reset_n  input  1  reset is asynchronous and active-low.
REQ-004 req_valid  input  NREQ  per-requester word valid.
REQ-005 req_data  input  NREQ*WIDTH  per-requester word; slice i belongs to requester i.
REQ-006 req_ready  output  NREQ  one-hot grant; word i is accepted when req_valid[i] & req_ready[i].
REQ-007 fifo_data  output  WIDTH  word written to the downstream FIFO.
REQ-008 fifo_id  output  $clog2(NREQ)  owner tag written with fifo_data.
REQ-009 fifo_we  output  1  downstream FIFO write strobe.
REQ-010 credit_ret  input  1  one credit returned, pulsed once per FIFO pop.
REQ-011 credit_id  input  $clog2(NREQ)  owner of the returned credit.
REQ-012 credit_err  output  1  sticky credit overflow or out-of-range id flag.
REQ-013 credit_cnt  output  NREQ*($clog2(CREDITS)+1)  current credit count per requester.

Function
REQ-014 Requester i SHALL be eligible when req_valid[i]=1 and credit[i]>0.
REQ-015 At most one req_ready bit SHALL be high per cycle, combinationally from eligibility and the round-robin pointer; no grant when no requester is eligible.
REQ-016 Arbitration SHALL be round-robin: search starts at pointer+1 mod NREQ; after a grant to i the pointer becomes i; the pointer holds when there is no grant.
REQ-017 On acceptance, fifo_data/fifo_id/fifo_we SHALL be registered, giving exactly 1 cycle latency; fifo_we=0 in cycles with no acceptance.
REQ-018 credit[i] SHALL decrement by 1 on acceptance from i and increment by 1 on credit_ret with credit_id=i; if both occur in the same cycle it is unchanged.
REQ-019 A return that would push credit[i] above CREDITS SHALL leave the count at CREDITS and set credit_err.
REQ-020 A credit_id >= NREQ SHALL be ignored for counting and SHALL set credit_err.
REQ-021 credit_err SHALL remain set until reset.
REQ-022 The sum of all credits SHALL never exceed DEPTH, so the downstream FIFO never sees a write while full.

Reset
REQ-023 While reset_n=0: credit[i]=CREDITS; pointer=NREQ-1 (so requester 0 is searched first); fifo_we=0; fifo_data=0; fifo_id=0; credit_err=0; req_ready=0.
REQ-024 Reset asserted mid-operation SHALL discard the in-flight fifo_we in that cycle and restore all credits; the environment resets the FIFO together with this block.

Configuration
REQ-025 Macro CREDIT_ARBITER_STATS_EN defined: add inputs stat_sel ($clog2(NREQ)) and stat_clr (1) and output stat_cnt (16); a per-requester 16-bit grant counter saturates at 0xFFFF, clears on stat_clr or reset, and stat_cnt=counter[stat_sel] combinationally.
REQ-026 Macro not defined: those ports and counters SHALL be absent and all other behaviour is identical.

Structure
REQ-027 Package credit_arbiter_pkg SHALL hold NREQ_MAX=8, the STAT_W=16 constant, and the typedef for the requester index.
REQ-028 Round-robin selection SHALL be the sub-module rr_arbiter (NREQ parameter; inputs: eligible vector and pointer; output: one-hot grant); credit counting and output registers stay in credit_arbiter.

Verification
REQ-029 Reset with all req_valid=1 and no returns: grants go 0,1,2,3,0,... for 32 cycles, then req_ready=0 with credit_cnt all 0; fifo_we is high in the 32 cycles following each grant.
REQ-030 Only requester 2 is valid: it receives 8 grants; after one credit_ret with id 2 it receives exactly one more grant, one cycle later.
REQ-031 Grant to 1 and credit_ret id 1 in the same cycle: credit[1] stays unchanged.
REQ-032 credit_ret id 0 while credit[0]=8: credit[0] stays 8 and credit_err=1 until reset_n=0.
REQ-033 reset_n pulsed low for an asynchronous 3 ns mid-burst: fifo_we=0 immediately, all credits=8, and the next grant goes to requester 0.
REQ-034 With CREDIT_ARBITER_STATS_EN, after test REQ-029: stat_cnt=8 for each stat_sel; after stat_clr, stat_cnt=0.
